// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD from the 100 Mb/s dibit stream
// and emits payload bytes LSB-first, marking the final byte with length/error.
module rmii_rx_deframer #(
  parameter int unsigned MAX_BYTES           = 1522,
  parameter int unsigned PREAMBLE_MIN_DIBITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        last_o,
  output logic        err_o,
  output logic [10:0] len_o
);

  localparam int unsigned LEN_W   = 11;
  localparam int unsigned PRE_W   = 6;
  localparam int unsigned PRE_SAT = 63;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_e;

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [1:0]         dibit_cnt_q, dibit_cnt_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         held_q, held_d;
  logic               held_vld_q, held_vld_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         new_byte;

  // Merge the incoming dibit into the partially assembled byte.
  always_comb begin
    new_byte = shift_q;
    new_byte[{dibit_cnt_q, 1'b0} +: 2] = rxd;
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    dibit_cnt_d = dibit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    held_d      = held_q;
    held_vld_d  = held_vld_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    err_d       = 1'b0;
    len_d       = len_q;

    unique case (state_q)
      S_IDLE: begin
        if (crsdv) begin
          unique case (rxd)
            2'b00: state_d = S_IDLE;
            2'b01: begin
              state_d   = S_PREAMBLE;
              pre_cnt_d = PRE_W'(1);
            end
            default: state_d = S_DROP;
          endcase
        end
      end

      S_PREAMBLE: begin
        if (!crsdv) begin
          state_d = S_IDLE;
        end else begin
          unique case (rxd)
            2'b01: begin
              if (32'(pre_cnt_q) != PRE_SAT) pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
            2'b11: begin
              if (32'(pre_cnt_q) >= PREAMBLE_MIN_DIBITS) begin
                state_d     = S_DATA;
                dibit_cnt_d = 2'd0;
                byte_cnt_d  = '0;
                held_vld_d  = 1'b0;
                shift_d     = '0;
              end else begin
                state_d = S_DROP;
              end
            end
            default: state_d = S_DROP;
          endcase
        end
      end

      S_DATA: begin
        if (crsdv) begin
          shift_d     = new_byte;
          dibit_cnt_d = dibit_cnt_q + 2'd1;
          if (dibit_cnt_q == 2'd3) begin
            if (32'(byte_cnt_q) == MAX_BYTES) begin
              // Byte MAX_BYTES+1 arrived: close the frame as oversize.
              data_d     = held_q;
              valid_d    = 1'b1;
              last_d     = 1'b1;
              err_d      = 1'b1;
              len_d      = LEN_W'(MAX_BYTES);
              held_vld_d = 1'b0;
              state_d    = S_DROP;
            end else begin
              if (held_vld_q) begin
                data_d  = held_q;
                valid_d = 1'b1;
              end
              held_d     = new_byte;
              held_vld_d = 1'b1;
              byte_cnt_d = byte_cnt_q + LEN_W'(1);
            end
          end
        end else begin
          if (held_vld_q) begin
            data_d  = held_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
            err_d   = (dibit_cnt_q != 2'd0);
            len_d   = byte_cnt_q;
          end
          held_vld_d  = 1'b0;
          dibit_cnt_d = 2'd0;
          state_d     = S_IDLE;
        end
      end

      S_DROP: begin
        if (!crsdv) state_d = S_IDLE;
      end

      default: state_d = S_DROP;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_DROP;
      pre_cnt_q   <= '0;
      dibit_cnt_q <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      held_q      <= '0;
      held_vld_q  <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      dibit_cnt_q <= dibit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      held_q      <= held_d;
      held_vld_q  <= held_vld_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
      len_q       <= len_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign err_o   = err_q;
  assign len_o   = len_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed bench for rmii_rx_deframer (MAX_BYTES=4 so oversize is reachable).
module tb_rmii_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic        crsdv;
  logic [1:0]  rxd;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        last_o;
  logic        err_o;
  logic [10:0] len_o;

  rmii_rx_deframer #(
    .MAX_BYTES          (4),
    .PREAMBLE_MIN_DIBITS(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .crsdv  (crsdv),
    .rxd    (rxd),
    .data_o (data_o),
    .valid_o(valid_o),
    .last_o (last_o),
    .err_o  (err_o),
    .len_o  (len_o)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  d;
    logic        l;
    logic        e;
    logic [10:0] n;
  } rec_t;

  rec_t recs[$];
  int   cyc = 0;
  int   last_samp = 0;
  int   stray = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Edge counter: value N after the N-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every strobe just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (valid_o) recs.push_back('{cyc: cyc, d: data_o, l: last_o, e: err_o, n: len_o});
    else if (last_o || err_o) stray++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic send_dibit(input logic dv, input logic [1:0] d);
    @(negedge clk);
    crsdv     = dv;
    rxd       = d;
    last_samp = cyc + 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) send_dibit(1'b1, b[2*i +: 2]);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) send_dibit(1'b1, 2'b01);
    send_dibit(1'b1, 2'b11);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_dibit(1'b0, 2'b00);
  endtask

  task automatic exp_rec(input string tag, input int idx, input logic [7:0] d,
                         input logic l, input logic e, input int n, input int c);
    if (idx < recs.size()) begin
      chk({tag, ".data"}, int'(recs[idx].d), int'(d));
      chk({tag, ".last"}, int'(recs[idx].l), int'(l));
      chk({tag, ".err"},  int'(recs[idx].e), int'(e));
      if (l) chk({tag, ".len"}, int'(recs[idx].n), n);
      chk({tag, ".cycle"}, recs[idx].cyc, c);
    end
  endtask

  int e1, e2, e3;
  int eb[6];

  initial begin
    rst   = 1'b1;
    crsdv = 1'b0;
    rxd   = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst.data",  int'(data_o),  0);
    chk("rst.valid", int'(valid_o), 0);
    chk("rst.last",  int'(last_o),  0);
    chk("rst.err",   int'(err_o),   0);
    chk("rst.len",   int'(len_o),   0);
    rst = 1'b0;
    idle(3);
    chk("rst.none", recs.size(), 0);

    // Standard frame, long preamble.
    recs.delete();
    preamble(31);
    send_byte(8'hA5); e1 = last_samp;
    send_byte(8'h3C); e2 = last_samp;
    send_dibit(1'b0, 2'b00); e3 = last_samp;
    idle(4);
    chk("std.count", recs.size(), 2);
    exp_rec("std.b0", 0, 8'hA5, 1'b0, 1'b0, 0, e2);
    exp_rec("std.b1", 1, 8'h3C, 1'b1, 1'b0, 2, e3);
    chk("std.gap", e2 - e1, 4);

    // PHY lead-in zeros before the preamble.
    recs.delete();
    for (int i = 0; i < 5; i++) send_dibit(1'b1, 2'b00);
    preamble(10);
    send_byte(8'h5A);
    send_dibit(1'b0, 2'b00); e1 = last_samp;
    idle(3);
    chk("lead.count", recs.size(), 1);
    exp_rec("lead.b0", 0, 8'h5A, 1'b1, 1'b0, 1, e1);

    // Corrupt preamble drops the frame; one idle sample then a clean frame.
    recs.delete();
    for (int i = 0; i < 6; i++) send_dibit(1'b1, 2'b01);
    send_dibit(1'b1, 2'b10);
    preamble(10);
    send_byte(8'h77);
    send_dibit(1'b0, 2'b00);
    chk("badpre.none", recs.size(), 0);
    preamble(8);
    send_byte(8'h99); e1 = last_samp;
    send_byte(8'h42); e2 = last_samp;
    send_dibit(1'b0, 2'b00); e3 = last_samp;
    idle(3);
    chk("badpre.count", recs.size(), 2);
    exp_rec("badpre.b0", 0, 8'h99, 1'b0, 1'b0, 0, e2);
    exp_rec("badpre.b1", 1, 8'h42, 1'b1, 1'b0, 2, e3);

    // Preamble shorter than the minimum.
    recs.delete();
    preamble(4);
    send_byte(8'h55);
    send_dibit(1'b0, 2'b00);
    idle(4);
    chk("short.none", recs.size(), 0);

    // Truncated mid-byte.
    recs.delete();
    preamble(8);
    send_byte(8'h11); e1 = last_samp;
    send_byte(8'h22); e2 = last_samp;
    send_dibit(1'b1, 2'b01);
    send_dibit(1'b1, 2'b10);
    send_dibit(1'b0, 2'b00); e3 = last_samp;
    idle(3);
    chk("trunc.count", recs.size(), 2);
    exp_rec("trunc.b0", 0, 8'h11, 1'b0, 1'b0, 0, e2);
    exp_rec("trunc.b1", 1, 8'h22, 1'b1, 1'b1, 2, e3);

    // Oversize: six bytes into a four-byte limit, then a normal frame.
    recs.delete();
    preamble(8);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(i + 1));
      eb[i] = last_samp;
    end
    send_dibit(1'b0, 2'b00);
    idle(2);
    chk("over.count", recs.size(), 4);
    exp_rec("over.b0", 0, 8'h01, 1'b0, 1'b0, 0, eb[1]);
    exp_rec("over.b1", 1, 8'h02, 1'b0, 1'b0, 0, eb[2]);
    exp_rec("over.b2", 2, 8'h03, 1'b0, 1'b0, 0, eb[3]);
    exp_rec("over.b3", 3, 8'h04, 1'b1, 1'b1, 4, eb[4]);
    recs.delete();
    preamble(8);
    send_byte(8'hC3);
    send_dibit(1'b0, 2'b00); e1 = last_samp;
    idle(3);
    chk("over.next.count", recs.size(), 1);
    exp_rec("over.next", 0, 8'hC3, 1'b1, 1'b0, 1, e1);

    // Reset one cycle after the second byte completes, carrier held high.
    recs.delete();
    preamble(8);
    send_byte(8'hAB);
    send_byte(8'hCD); e1 = last_samp;
    @(negedge clk);
    rst   = 1'b1;
    crsdv = 1'b1;
    rxd   = 2'b01;
    @(posedge clk);
    #1;
    chk("mrst.data",  int'(data_o),  0);
    chk("mrst.valid", int'(valid_o), 0);
    chk("mrst.last",  int'(last_o),  0);
    chk("mrst.err",   int'(err_o),   0);
    chk("mrst.len",   int'(len_o),   0);
    @(negedge clk);
    rst = 1'b0;
    preamble(8);
    send_byte(8'hEE);
    send_byte(8'hEF);
    idle(1);
    chk("mrst.drop.count", recs.size(), 1);
    preamble(8);
    send_byte(8'h3D);
    send_dibit(1'b0, 2'b00); e2 = last_samp;
    idle(4);
    chk("mrst.count", recs.size(), 2);
    exp_rec("mrst.b0", 0, 8'hAB, 1'b0, 1'b0, 0, e1);
    exp_rec("mrst.next", 1, 8'h3D, 1'b1, 1'b0, 1, e2);

    chk("stray.last_err", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
